ray_scan_sequencer: RTL and testbench
=====================================

Name: ray_scan_sequencer

Overview:
- Sequences a single ray scanner (diagonal and orthogonal nearest-piece lookup) across every ray direction a sliding piece can use.
- For each enabled direction it issues one scan, waits the scanner's fixed latency, then walks the ray one square per cycle, building a 64-bit attack mask.
- Sits between move generation/validation and the shared scanner. It is the scanner's only requester.

Parameters:
- SCAN_LATENCY, 1: clock cycles from `scan_valid` high until `scan_found`/`scan_nearest_*` are valid. Legal range 1-7.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: request a scan job. Sampled only in IDLE.
- `origin` in 6: square of the moving piece; row = `origin[5:3]`, col = `origin[2:0]`.
- `kind` in 2: 00 none, 01 bishop (dirs 0-3), 10 rook (dirs 4-7), 11 queen (dirs 0-7).
- `color` in 1: mover colour; compared against piece bit 3.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` out 1: one-cycle pulse; `attack_mask`/`capture_count` are final.
- `attack_mask` out 64: bit n set = square n reachable or capturable.
- `capture_count` out 4: number of opposite-colour blockers included in the mask.
- `scan_valid` out 1: one-cycle scan issue strobe.
- `scan_dir` out 3: direction code of the current scan.
- `scan_pos` out 6: origin square for the current scan.
- `scan_found` in 1: scanner found an occupied square on the ray.
- `scan_nearest_pos` in 6: square of the nearest piece (valid if `scan_found`).
- `scan_nearest_piece` in 4: [2:0] type (000 = empty), [3] colour.

Behaviour:
- Reset (async, `rst_n`=0): state IDLE; `busy`, `done`, `scan_valid`=0; `scan_dir`, `scan_pos`=0; `attack_mask`=0; `capture_count`=0; direction index=0. Reset mid-job aborts immediately, with no `done`.
- Direction codes as (drow,dcol): 0 (-1,-1), 1 (-1,+1), 2 (+1,-1), 3 (+1,+1), 4 (-1,0), 5 (+1,0), 6 (0,-1), 7 (0,+1).
- Edge test uses row/col separately. A step leaving row or col range 0..7 terminates the ray; there is no wrap from col 7 to col 0 of the next row.
- FSM states: IDLE, ISSUE, WAIT, WALK, DONE.
- IDLE:
  - On `start`=1, latch `origin`/`kind`/`color`, clear `attack_mask` and `capture_count`, select the first enabled direction.
  - If `kind`=00, go straight to DONE; otherwise go to ISSUE.
  - While not IDLE, `start` is ignored and not queued.
- ISSUE (1 cycle): `scan_valid`=1, `scan_dir`=current dir, `scan_pos`=latched origin → WAIT.
- WAIT: count SCAN_LATENCY cycles. On the last count, register `scan_found`, `scan_nearest_pos`, `scan_nearest_piece` → WALK, with walk square = origin + 1 step.
- WALK, one cycle per square:
  - If walk square is off-board, or (`scan_found` and walk square == nearest and nearest colour == mover colour): end ray, no bit set.
  - Else if `scan_found` and walk square == nearest (opposite colour): set bit, `capture_count`+1, end ray.
  - Else: set bit, advance one step, stay in WALK.
  - An ending ray still occupies its final WALK cycle.
  - On ray end, select the next enabled direction → ISSUE, or DONE if none remain.
- DONE (1 cycle): `done`=1, `busy`=1 → IDLE. `attack_mask`/`capture_count` hold until the next accepted `start`.
- Timing: cycle 1 = first ISSUE (cycle after `start` edge). Per direction = 1 + SCAN_LATENCY + max(1, squares examined). `done` is high in cycle (sum over dirs)+1.
- `scan_*` inputs are ignored outside the final WAIT cycle. `scan_found`=1 with a piece type of 000 is treated as not found.
- `capture_count` saturates at 8, which is unreachable in practice.

Test Plan:
1. Empty board, bishop, `origin`=27, SCAN_LATENCY=1 → mask bits {0,9,18,6,13,20,34,41,48,36,45,54,63}, `capture_count`=0, `done` in cycle 22, `busy` low in cycle 23.
2. Rook, `origin`=0, scanner returns found at 3 (opposite colour) for dir 7 and found at 16 (same colour) for dir 5, none elsewhere → mask bits {1,2,3,8}, `capture_count`=1. Dirs 4 and 6 each take 1 WALK cycle.
3. Queen at `origin`=7 (row0 col7) on empty board → no bit in col 0 of row 1 (no wrap). Mask = 7 row-0 squares + 7 col-7 squares + 7 anti-diagonal squares = 21 bits.
4. `kind`=00 with `start` → `done` in cycle 1, mask 0, `scan_valid` never asserted.
5. `start` re-pulsed while `busy`, and SCAN_LATENCY=3 → second start ignored. First job result unchanged; each direction's WAIT lasts exactly 3 cycles.
6. `rst_n` asserted during WALK of dir 2 → all outputs 0 asynchronously, no `done`. A subsequent `start` runs a full clean job.

Source files
------------

// File: rtl/ray_scan_sequencer_if.sv
// Scanner bus between the ray scan sequencer (master) and the shared
// nearest-piece ray scanner (slave).
interface ray_scan_sequencer_if;
  logic       scan_valid;
  logic [2:0] scan_dir;
  logic [5:0] scan_pos;
  logic       scan_found;
  logic [5:0] scan_nearest_pos;
  logic [3:0] scan_nearest_piece;

  modport master (
    output scan_valid,
    output scan_dir,
    output scan_pos,
    input  scan_found,
    input  scan_nearest_pos,
    input  scan_nearest_piece
  );

  modport slave (
    input  scan_valid,
    input  scan_dir,
    input  scan_pos,
    output scan_found,
    output scan_nearest_pos,
    output scan_nearest_piece
  );
endinterface

// File: rtl/ray_scan_sequencer.sv
// Ray scan sequencer: walks every enabled sliding direction of a bishop,
// rook or queen, issuing one scanner request per direction and building
// the attack mask one square per cycle.
module ray_scan_sequencer #(
  parameter int unsigned SCAN_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [5:0]           origin,
  input  logic [1:0]           kind,
  input  logic                 color,
  output logic                 busy,
  output logic                 done,
  output logic [63:0]          attack_mask,
  output logic [3:0]           capture_count,
  ray_scan_sequencer_if.master scan
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WALK,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [5:0] origin_r;
  logic [1:0] kind_r;
  logic       color_r;
  logic [2:0] dir_r;
  logic [2:0] wait_cnt;
  logic       found_r;
  logic [5:0] npos_r;
  logic       ncolor_r;
  logic [3:0] wrow;
  logic [3:0] wcol;

  logic       wait_last;
  logic [3:0] first_sel;
  logic [3:0] next_sel;
  logic [5:0] wsq;
  logic       off_board;
  logic       hit;
  logic       same_blk;
  logic       set_bit;
  logic       take_cap;
  logic [3:0] nrow;
  logic [3:0] ncol;
  logic       ray_end;

  // Directions 0-3 are diagonals, 4-7 orthogonals.
  function automatic logic [7:0] dir_enables(input logic [1:0] k);
    case (k)
      2'b01:   return 8'h0F;
      2'b10:   return 8'hF0;
      2'b11:   return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // Row step as a 4-bit two's-complement delta.
  function automatic logic [3:0] step_row(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd4: return 4'hF;
      3'd2, 3'd3, 3'd5: return 4'h1;
      default:          return 4'h0;
    endcase
  endfunction

  // Column step as a 4-bit two's-complement delta.
  function automatic logic [3:0] step_col(input logic [2:0] d);
    case (d)
      3'd0, 3'd2, 3'd6: return 4'hF;
      3'd1, 3'd3, 3'd7: return 4'h1;
      default:          return 4'h0;
    endcase
  endfunction

  // Lowest set bit of en as {found, index}.
  function automatic logic [3:0] pick_dir(input logic [7:0] en);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (en[i] && !r[3]) begin
        r = {1'b1, 3'(i)};
      end
    end
    return r;
  endfunction

  assign wait_last = (wait_cnt == 3'(SCAN_LATENCY - 1));
  assign first_sel = pick_dir(dir_enables(kind));
  assign next_sel  = pick_dir(dir_enables(kind_r) & (8'hFE << dir_r));

  // Walk-square evaluation. Row/col carry a 4th bit so a step off either
  // edge shows up as bit 3 set (-1 -> 4'hF, 8 -> 4'h8); no wrap between rows.
  // The ray also ends on the last on-board square, so the off-board step
  // never costs its own cycle unless it is the very first step.
  always_comb begin
    wsq       = {wrow[2:0], wcol[2:0]};
    off_board = wrow[3] | wcol[3];
    hit       = found_r & ~off_board & (wsq == npos_r);
    same_blk  = hit & (ncolor_r == color_r);
    set_bit   = ~off_board & ~same_blk;
    take_cap  = hit & ~same_blk;
    nrow      = wrow + step_row(dir_r);
    ncol      = wcol + step_col(dir_r);
    ray_end   = off_board | hit | nrow[3] | ncol[3];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (kind == 2'b00) ? DONE : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_last) state_nxt = WALK;
      WALK:    if (ray_end) state_nxt = next_sel[3] ? ISSUE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy            = (state != IDLE);
    done            = (state == DONE);
    scan.scan_valid = (state == ISSUE);
    scan.scan_dir   = dir_r;
    scan.scan_pos   = origin_r;
  end

  // Job datapath: latched request, scan result, walk position, mask and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      origin_r      <= '0;
      kind_r        <= '0;
      color_r       <= 1'b0;
      dir_r         <= '0;
      wait_cnt      <= '0;
      found_r       <= 1'b0;
      npos_r        <= '0;
      ncolor_r      <= 1'b0;
      wrow          <= '0;
      wcol          <= '0;
      attack_mask   <= '0;
      capture_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            origin_r      <= origin;
            kind_r        <= kind;
            color_r       <= color;
            attack_mask   <= '0;
            capture_count <= '0;
            dir_r         <= first_sel[2:0];
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_last) begin
            found_r  <= scan.scan_found & (scan.scan_nearest_piece[2:0] != 3'b000);
            npos_r   <= scan.scan_nearest_pos;
            ncolor_r <= scan.scan_nearest_piece[3];
            wrow     <= {1'b0, origin_r[5:3]} + step_row(dir_r);
            wcol     <= {1'b0, origin_r[2:0]} + step_col(dir_r);
          end
        end
        WALK: begin
          if (set_bit) begin
            attack_mask[wsq] <= 1'b1;
          end
          if (take_cap && (capture_count != 4'd8)) begin
            capture_count <= capture_count + 4'd1;
          end
          if (ray_end) begin
            if (next_sel[3]) begin
              dir_r <= next_sel[2:0];
            end
          end else begin
            wrow <= nrow;
            wcol <= ncol;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_scan_sequencer.sv
// Self-checking bench for ray_scan_sequencer: a board-backed scanner model
// answers requests, and a ray-walking reference model predicts mask,
// capture count and done timing.
module tb_ray_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  origin;
  logic [1:0]  kind;
  logic        color;
  bit          sel3;
  logic        start1, start3;
  logic        busy1, done1, busy3, done3;
  logic [63:0] mask1, mask3;
  logic [3:0]  cc1, cc3;
  logic        busy_s, done_s, sv_s;
  logic [63:0] mask_s;
  logic [3:0]  cc_s;

  logic [3:0]  board [64];
  int          drow_t [8] = '{-1, -1, 1, 1, -1, 1, 0, 0};
  int          dcol_t [8] = '{-1, 1, -1, 1, 0, 0, -1, 1};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ray_scan_sequencer_if if1 ();
  ray_scan_sequencer_if if3 ();

  assign start1 = start & ~sel3;
  assign start3 = start & sel3;

  ray_scan_sequencer #(.SCAN_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .origin(origin), .kind(kind),
    .color(color), .busy(busy1), .done(done1), .attack_mask(mask1),
    .capture_count(cc1), .scan(if1)
  );

  ray_scan_sequencer #(.SCAN_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .origin(origin), .kind(kind),
    .color(color), .busy(busy3), .done(done3), .attack_mask(mask3),
    .capture_count(cc3), .scan(if3)
  );

  assign busy_s = sel3 ? busy3 : busy1;
  assign done_s = sel3 ? done3 : done1;
  assign sv_s   = sel3 ? if3.scan_valid : if1.scan_valid;
  assign mask_s = sel3 ? mask3 : mask1;
  assign cc_s   = sel3 ? cc3 : cc1;

  // Nearest occupied square along a ray: {found, pos, piece}. An empty ray
  // returns a random found bit with piece type 000, which must read as empty.
  function automatic logic [10:0] nearest(input logic [5:0] pos, input logic [2:0] dir);
    int r, c;
    r = int'(pos[5:3]);
    c = int'(pos[2:0]);
    for (int k = 0; k < 8; k++) begin
      r = r + drow_t[dir];
      c = c + dcol_t[dir];
      if (r < 0 || r > 7 || c < 0 || c > 7) break;
      if (board[r*8+c][2:0] != 3'b000) return {1'b1, 6'(r*8+c), board[r*8+c]};
    end
    return {1'($urandom), 6'($urandom), 1'($urandom), 3'b000};
  endfunction

  // Scanner models: the true answer is presented only in the cycle exactly
  // LAT cycles after the request; every other cycle carries random junk.
  int          k1 = 0, k3 = 0;
  logic [2:0]  d1, d3;
  logic [5:0]  p1, p3;
  always @(posedge clk) begin
    logic [10:0] rsp;
    if (if1.scan_valid) begin k1 = 1; d1 = if1.scan_dir; p1 = if1.scan_pos; end
    else if (k1 != 0) k1 = k1 + 1;
    rsp = (k1 == 1) ? nearest(p1, d1) : 11'($urandom);
    if (k1 == 1) k1 = 0;
    {if1.scan_found, if1.scan_nearest_pos, if1.scan_nearest_piece} <= rsp;
  end
  always @(posedge clk) begin
    logic [10:0] rsp;
    if (if3.scan_valid) begin k3 = 1; d3 = if3.scan_dir; p3 = if3.scan_pos; end
    else if (k3 != 0) k3 = k3 + 1;
    rsp = (k3 == 3) ? nearest(p3, d3) : 11'($urandom);
    if (k3 == 3) k3 = 0;
    {if3.scan_found, if3.scan_nearest_pos, if3.scan_nearest_piece} <= rsp;
  end

  // Reference: walk each enabled ray on the board.
  task automatic model(input logic [5:0] org, input logic [1:0] kd, input logic col,
                       input int lat, output logic [63:0] m, output int cap,
                       output int cyc, output int nd);
    int r, c, n, sq;
    m = '0; cap = 0; cyc = 0; nd = 0;
    for (int d = 0; d < 8; d++) begin
      if (!((d < 4) ? kd[0] : kd[1])) continue;
      nd++;
      r = int'(org[5:3]);
      c = int'(org[2:0]);
      n = 0;
      for (int k = 0; k < 8; k++) begin
        r = r + drow_t[d];
        c = c + dcol_t[d];
        if (r < 0 || r > 7 || c < 0 || c > 7) break;
        n++;
        sq = r * 8 + c;
        if (board[sq][2:0] != 3'b000) begin
          if (board[sq][3] != col) begin m[sq] = 1'b1; cap++; end
          break;
        end
        m[sq] = 1'b1;
      end
      cyc = cyc + 1 + lat + ((n > 0) ? n : 1);
    end
    cyc = cyc + 1;
  endtask

  // Runs one job on the selected DUT and reports what was observed.
  task automatic run_job(input logic [5:0] org, input logic [1:0] kd, input logic col,
                         input bit repulse, output logic [63:0] m, output int cap,
                         output int dcyc, output int nvalid, output bit busy_bad,
                         output bit busy_after, output bit held_bad);
    int cyc;
    @(negedge clk);
    origin = org; kind = kd; color = col; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; dcyc = 0; nvalid = 0; busy_bad = 0; held_bad = 0;
    while (cyc < 400) begin
      if (sv_s) nvalid++;
      if (!busy_s) busy_bad = 1;
      if (done_s) begin dcyc = cyc; break; end
      if (repulse && cyc == 4) begin
        origin = ~org; kind = 2'b11; color = ~col; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    m = mask_s;
    cap = int'(cc_s);
    @(negedge clk);
    busy_after = busy_s;
    for (int i = 0; i < 3; i++) begin
      if (mask_s !== m) held_bad = 1;
      @(negedge clk);
      if (busy_s) busy_after = 1;
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 4'h0;
  endtask

  task automatic random_board();
    for (int i = 0; i < 64; i++)
      board[i] = ($urandom_range(0, 3) == 0) ? {1'($urandom), 3'($urandom_range(1, 7))} : 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, done1, if1.scan_valid, busy3, done3, if3.scan_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
                         {busy1, done1, if1.scan_valid, busy3, done3, if3.scan_valid});
    end
    checks++;
    if ({if1.scan_dir, if1.scan_pos} !== 9'd0) begin
      errors++; $display("FAIL reset_scan got %h want 0", {if1.scan_dir, if1.scan_pos});
    end
    checks++;
    if ({mask1, cc1} !== 68'd0) begin
      errors++; $display("FAIL reset_result got %h want 0", {mask1, cc1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bishop_empty();
    logic [63:0] m, exp;
    int cap, dc, nv;
    bit bb, ba, hb;
    int bits [13] = '{0, 9, 18, 6, 13, 20, 34, 41, 48, 36, 45, 54, 63};
    clear_board(); sel3 = 0;
    exp = '0;
    foreach (bits[i]) exp[bits[i]] = 1'b1;
    run_job(6'd27, 2'b01, 1'b0, 0, m, cap, dc, nv, bb, ba, hb);
    checks++; if (m !== exp) begin errors++; $display("FAIL bishop_mask got %h want %h", m, exp); end
    checks++; if (cap !== 0) begin errors++; $display("FAIL bishop_cap got %0d want 0", cap); end
    checks++; if (dc !== 22) begin errors++; $display("FAIL bishop_done_cycle got %0d want 22", dc); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL bishop_busy_after got %b want 0", ba); end
    checks++; if (bb !== 1'b0) begin errors++; $display("FAIL bishop_busy_during got gap want none"); end
    checks++; if (nv !== 4) begin errors++; $display("FAIL bishop_issues got %0d want 4", nv); end
  endtask

  task automatic test_rook_blockers();
    logic [63:0] m, exp;
    int cap, dc, nv;
    bit bb, ba, hb;
    clear_board(); sel3 = 0;
    board[3]  = 4'hA;
    board[16] = 4'h3;
    exp = '0; exp[1] = 1'b1; exp[2] = 1'b1; exp[3] = 1'b1; exp[8] = 1'b1;
    run_job(6'd0, 2'b10, 1'b0, 0, m, cap, dc, nv, bb, ba, hb);
    checks++; if (m !== exp) begin errors++; $display("FAIL rook_mask got %h want %h", m, exp); end
    checks++; if (cap !== 1) begin errors++; $display("FAIL rook_cap got %0d want 1", cap); end
    checks++; if (dc !== 16) begin errors++; $display("FAIL rook_done_cycle got %0d want 16", dc); end
    checks++; if (hb !== 1'b0) begin errors++; $display("FAIL rook_hold got changed want held"); end
  endtask

  task automatic test_queen_nowrap();
    logic [63:0] m, em;
    int cap, dc, nv, ec, ecyc, end_;
    bit bb, ba, hb;
    clear_board(); sel3 = 0;
    model(6'd7, 2'b11, 1'b1, 1, em, ec, ecyc, end_);
    run_job(6'd7, 2'b11, 1'b1, 0, m, cap, dc, nv, bb, ba, hb);
    checks++; if (m[8] !== 1'b0) begin errors++; $display("FAIL queen_wrap got bit8=%b want 0", m[8]); end
    checks++; if ($countones(m) !== 21) begin errors++; $display("FAIL queen_popcount got %0d want 21", $countones(m)); end
    checks++; if (m !== em) begin errors++; $display("FAIL queen_mask got %h want %h", m, em); end
    checks++; if (dc !== ecyc) begin errors++; $display("FAIL queen_done_cycle got %0d want %0d", dc, ecyc); end
  endtask

  task automatic test_kind_none();
    logic [63:0] m;
    int cap, dc, nv;
    bit bb, ba, hb;
    random_board(); sel3 = 0;
    run_job(6'd27, 2'b11, 1'b0, 0, m, cap, dc, nv, bb, ba, hb);
    run_job(6'd35, 2'b00, 1'b0, 0, m, cap, dc, nv, bb, ba, hb);
    checks++; if (dc !== 1) begin errors++; $display("FAIL none_done_cycle got %0d want 1", dc); end
    checks++; if (m !== 64'd0) begin errors++; $display("FAIL none_mask got %h want 0", m); end
    checks++; if (nv !== 0) begin errors++; $display("FAIL none_issues got %0d want 0", nv); end
    checks++; if (cap !== 0) begin errors++; $display("FAIL none_cap got %0d want 0", cap); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] m, em;
    int cap, dc, nv, ec, ecyc, end_;
    bit bb, ba, hb;
    logic [5:0] org;
    logic [1:0] kd;
    sel3 = 1;
    for (int j = 0; j < 3; j++) begin
      random_board();
      org = 6'($urandom);
      kd  = (j == 0) ? 2'b01 : 2'($urandom_range(1, 3));
      model(org, kd, 1'b0, 3, em, ec, ecyc, end_);
      run_job(org, kd, 1'b0, 1, m, cap, dc, nv, bb, ba, hb);
      checks++; if (m !== em) begin errors++; $display("FAIL b2b_mask[%0d] got %h want %h", j, m, em); end
      checks++; if (cap !== ec) begin errors++; $display("FAIL b2b_cap[%0d] got %0d want %0d", j, cap, ec); end
      checks++; if (dc !== ecyc) begin errors++; $display("FAIL b2b_done_cycle[%0d] got %0d want %0d", j, dc, ecyc); end
      checks++; if (nv !== end_) begin errors++; $display("FAIL b2b_issues[%0d] got %0d want %0d", j, nv, end_); end
      checks++; if (ba !== 1'b0) begin errors++; $display("FAIL b2b_requeued[%0d] got busy want idle", j); end
    end
    sel3 = 0;
  endtask

  task automatic test_reset_mid_walk();
    logic [63:0] m, em;
    int cap, dc, nv, ec, ecyc, end_, seen, cyc;
    bit bb, ba, hb, got_done;
    clear_board(); sel3 = 0;
    @(negedge clk);
    origin = 6'd27; kind = 2'b01; color = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0; cyc = 0;
    while (seen < 3 && cyc < 100) begin
      if (sv_s) seen++;
      if (seen < 3) begin @(negedge clk); cyc++; end
    end
    checks++; if (seen !== 3) begin errors++; $display("FAIL midwalk_reach got %0d issues want 3", seen); end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, if1.scan_valid, if1.scan_dir, if1.scan_pos, cc1} !== 16'd0 || mask1 !== 64'd0) begin
      errors++; $display("FAIL midwalk_async got busy=%b dir=%0d mask=%h want all 0", busy1, if1.scan_dir, mask1);
    end
    got_done = 0;
    repeat (3) begin @(negedge clk); if (done1) got_done = 1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done1 || busy1) got_done = 1; end
    checks++; if (got_done !== 1'b0) begin errors++; $display("FAIL midwalk_nodone got activity want none"); end
    random_board();
    model(6'd27, 2'b01, 1'b1, 1, em, ec, ecyc, end_);
    run_job(6'd27, 2'b01, 1'b1, 0, m, cap, dc, nv, bb, ba, hb);
    checks++; if (m !== em) begin errors++; $display("FAIL midwalk_rerun_mask got %h want %h", m, em); end
    checks++; if (dc !== ecyc) begin errors++; $display("FAIL midwalk_rerun_cycle got %0d want %0d", dc, ecyc); end
  endtask

  task automatic test_random();
    logic [63:0] m, em;
    int cap, dc, nv, ec, ecyc, end_;
    bit bb, ba, hb;
    logic [5:0] org;
    logic [1:0] kd;
    logic col;
    for (int j = 0; j < 30; j++) begin
      random_board();
      sel3 = j[0];
      org = 6'($urandom);
      kd  = 2'($urandom);
      col = 1'($urandom);
      model(org, kd, col, sel3 ? 3 : 1, em, ec, ecyc, end_);
      run_job(org, kd, col, 0, m, cap, dc, nv, bb, ba, hb);
      checks++; if (m !== em) begin errors++; $display("FAIL rand_mask[%0d] got %h want %h", j, m, em); end
      checks++; if (cap !== ec) begin errors++; $display("FAIL rand_cap[%0d] got %0d want %0d", j, cap, ec); end
      checks++; if (dc !== ecyc) begin errors++; $display("FAIL rand_done_cycle[%0d] got %0d want %0d", j, dc, ecyc); end
    end
    sel3 = 0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; origin = '0; kind = '0; color = 1'b0; sel3 = 0;
    clear_board();
    test_reset();
    test_bishop_empty();
    test_rook_blockers();
    test_queen_nowrap();
    test_kind_none();
    test_back_to_back();
    test_reset_mid_walk();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
